// File: rtl/regfile_mp.sv
// Multi-port integer register file: three combinational read ports, two write lanes
// (lane 1 younger), optional XZR and write-to-read bypass, and a sequenced bulk-clear engine.
module regfile_mp #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 5,
  parameter int NUM_REGS       = 32,
  parameter int ZERO_REG_EN    = 1,
  parameter int ZERO_REG_INDEX = 31,
  parameter int BYPASS_EN      = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] read_register1,
  input  logic [ADDR_WIDTH-1:0] read_register2,
  input  logic [ADDR_WIDTH-1:0] read_register3,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [DATA_WIDTH-1:0] read_data3,
  input  logic                  reg_write0,
  input  logic                  reg_write1,
  input  logic [ADDR_WIDTH-1:0] write_register0,
  input  logic [ADDR_WIDTH-1:0] write_register1,
  input  logic [DATA_WIDTH-1:0] write_data0,
  input  logic [DATA_WIDTH-1:0] write_data1,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done
);

  localparam int IDX_WIDTH = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clear_cnt;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  logic                    we0;
  logic                    we1;

  // True for an implemented, writable register (in range and not XZR).
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] idx);
    return (int'(idx) < NUM_REGS) &&
           !((ZERO_REG_EN != 0) && (int'(idx) == ZERO_REG_INDEX));
  endfunction

  assign we0 = reg_write0 && addr_ok(write_register0) && !clear_busy;
  assign we1 = reg_write1 && addr_ok(write_register1) && !clear_busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      clear_cnt  <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            clear_cnt  <= '0;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clear_cnt == LAST_INDEX) begin
            state      <= DONE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            clear_cnt <= clear_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array is reset asynchronously because a reset during CLEAR must leave every
  // entry at zero; this deliberately keeps the storage in flops rather than a RAM macro.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[clear_cnt[IDX_WIDTH-1:0]] <= '0;
    end else begin
      // Lane 1 is assigned last so it wins when both lanes hit the same index.
      if (we0) regs[write_register0[IDX_WIDTH-1:0]] <= write_data0;
      if (we1) regs[write_register1[IDX_WIDTH-1:0]] <= write_data1;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    if (!reset_n || !addr_ok(idx)) return '0;
    if ((BYPASS_EN != 0) && we1 && (write_register1 == idx)) return write_data1;
    if ((BYPASS_EN != 0) && we0 && (write_register0 == idx)) return write_data0;
    return regs[idx[IDX_WIDTH-1:0]];
  endfunction

  always_comb begin
    read_data1 = read_port(read_register1);
    read_data2 = read_port(read_register2);
    read_data3 = read_port(read_register3);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build plus a no-XZR build and a 16-entry,
// no-bypass build, all driven from the same stimulus.
module tb_regfile_mp;

  logic        clock;
  logic        reset_n;
  logic [4:0]  rr1, rr2, rr3;
  logic        reg_write0, reg_write1;
  logic [4:0]  wr0, wr1;
  logic [63:0] wd0, wd1;
  logic        clear_start;

  logic [63:0] rd1, rd2, rd3;
  logic        clear_busy, clear_done;
  logic [63:0] za_rd1, za_rd2, za_rd3;
  logic        za_busy, za_done;
  logic [63:0] sm_rd1, sm_rd2, sm_rd3;
  logic        sm_busy, sm_done;

  int n_vec = 0;
  int n_err = 0;

  regfile_mp dut (
    .clock(clock), .reset_n(reset_n),
    .read_register1(rr1), .read_register2(rr2), .read_register3(rr3),
    .read_data1(rd1), .read_data2(rd2), .read_data3(rd3),
    .reg_write0(reg_write0), .reg_write1(reg_write1),
    .write_register0(wr0), .write_register1(wr1),
    .write_data0(wd0), .write_data1(wd1),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  regfile_mp #(.ZERO_REG_EN(0)) u_nz (
    .clock(clock), .reset_n(reset_n),
    .read_register1(rr1), .read_register2(rr2), .read_register3(rr3),
    .read_data1(za_rd1), .read_data2(za_rd2), .read_data3(za_rd3),
    .reg_write0(reg_write0), .reg_write1(reg_write1),
    .write_register0(wr0), .write_register1(wr1),
    .write_data0(wd0), .write_data1(wd1),
    .clear_start(clear_start), .clear_busy(za_busy), .clear_done(za_done)
  );

  regfile_mp #(.NUM_REGS(16), .BYPASS_EN(0)) u_small (
    .clock(clock), .reset_n(reset_n),
    .read_register1(rr1), .read_register2(rr2), .read_register3(rr3),
    .read_data1(sm_rd1), .read_data2(sm_rd2), .read_data3(sm_rd3),
    .reg_write0(reg_write0), .reg_write1(reg_write1),
    .write_register0(wr0), .write_register1(wr1),
    .write_data0(wd0), .write_data1(wd1),
    .clear_start(clear_start), .clear_busy(sm_busy), .clear_done(sm_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic no_writes();
    reg_write0 = 1'b0;
    reg_write1 = 1'b0;
  endtask

  // x(2i) = 2i+1 via lane 0 and x(2i+1) = 2i+2 via lane 1, so every xN holds N+1.
  task automatic preload();
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      reg_write0 = 1'b1; wr0 = 5'(2 * i);     wd0 = 64'(2 * i + 1);
      reg_write1 = 1'b1; wr1 = 5'(2 * i + 1); wd1 = 64'(2 * i + 2);
    end
    @(negedge clock);
    no_writes();
  endtask

  // Observes the clear handshake for a bounded number of cycles; with inject set it also
  // attempts writes, reads and a second clear_start while CLEAR is running.
  task automatic watch(input int cycles, input bit inject,
                       output int busy_n, output int done_n, output int busy_at_done);
    busy_n = 0;
    done_n = 0;
    busy_at_done = -1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      clear_start = 1'b0;
      no_writes();
      if (clear_done) begin
        done_n++;
        if (busy_at_done < 0) busy_at_done = busy_n;
      end
      if (clear_busy) begin
        if (inject && busy_n == 5) begin
          reg_write0 = 1'b1; wr0 = 5'd3;  wd0 = 64'h55; rr1 = 5'd3;
          reg_write1 = 1'b1; wr1 = 5'd20; wd1 = 64'h77; rr3 = 5'd20;
          rr2 = 5'd10;
          #1;
          check("mid_clear_x3_cleared_no_bypass", rd1, 64'h0);
          check("mid_clear_x10_not_yet_cleared", rd2, 64'd11);
          check("mid_clear_x20_no_bypass", rd3, 64'd21);
        end
        if (inject && busy_n == 7) clear_start = 1'b1;
        busy_n++;
      end
    end
    clear_start = 1'b0;
  endtask

  initial begin
    int busy_n, done_n, busy_at_done;

    reset_n = 1'b0;
    clear_start = 1'b0;
    rr1 = 5'd5; rr2 = 5'd0; rr3 = 5'd31;
    reg_write0 = 1'b1; wr0 = 5'd5; wd0 = 64'hDEAD_BEEF;
    reg_write1 = 1'b0; wr1 = 5'd0; wd1 = 64'h0;
    #3;
    check("reset_read_bypass_blocked", rd1, 64'h0);
    check("reset_read2", rd2, 64'h0);
    check("reset_busy", {63'h0, clear_busy}, 64'h0);
    check("reset_done", {63'h0, clear_done}, 64'h0);
    @(negedge clock);
    no_writes();
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i); rr2 = 5'((i + 11) % 32); rr3 = 5'((i + 22) % 32);
      #1;
      check("post_reset_rd1", rd1, 64'h0);
      check("post_reset_rd2", rd2, 64'h0);
      check("post_reset_rd3", rd3, 64'h0);
    end

    // Lane 0 write of x5, bypassed in the write cycle on the default build only.
    @(negedge clock);
    reg_write0 = 1'b1; wr0 = 5'd5; wd0 = 64'hDEAD_BEEF; rr1 = 5'd5; rr2 = 5'd4;
    #1;
    check("x5_bypass", rd1, 64'hDEAD_BEEF);
    check("x5_nobypass_old", sm_rd1, 64'h0);
    @(negedge clock);
    no_writes();
    #1;
    check("x5_stored", rd1, 64'hDEAD_BEEF);
    check("x4_untouched", rd2, 64'h0);
    check("x5_nobypass_stored", sm_rd1, 64'hDEAD_BEEF);

    // Both lanes to x7: lane 1 wins, both in bypass and in storage.
    @(negedge clock);
    reg_write0 = 1'b1; wr0 = 5'd7; wd0 = 64'h11;
    reg_write1 = 1'b1; wr1 = 5'd7; wd1 = 64'h22; rr3 = 5'd7;
    #1;
    check("x7_bypass_lane1_wins", rd3, 64'h22);
    check("x7_nobypass_old", sm_rd3, 64'h0);
    @(negedge clock);
    no_writes();
    #1;
    check("x7_stored_lane1", rd3, 64'h22);
    check("x7_small_stored_lane1", sm_rd3, 64'h22);

    // Lanes to different indices, each bypassed to its own port.
    @(negedge clock);
    reg_write0 = 1'b1; wr0 = 5'd8; wd0 = 64'hA;
    reg_write1 = 1'b1; wr1 = 5'd9; wd1 = 64'hB; rr1 = 5'd8; rr2 = 5'd9;
    #1;
    check("x8_bypass_lane0", rd1, 64'hA);
    check("x9_bypass_lane1", rd2, 64'hB);
    check("x7_unaffected", rd3, 64'h22);
    @(negedge clock);
    no_writes();
    #1;
    check("x8_stored", rd1, 64'hA);
    check("x9_stored", rd2, 64'hB);

    // XZR: ignored with ZERO_REG_EN=1, ordinary register otherwise, out of range at 16 entries.
    @(negedge clock);
    reg_write0 = 1'b1; wr0 = 5'd31; wd0 = 64'hFFFF; rr1 = 5'd31;
    #1;
    check("x31_zero_reg_bypass", rd1, 64'h0);
    check("x31_nz_bypass", za_rd1, 64'hFFFF);
    check("x31_small_out_of_range", sm_rd1, 64'h0);
    @(negedge clock);
    no_writes();
    #1;
    check("x31_zero_reg_stored", rd1, 64'h0);
    check("x31_nz_stored", za_rd1, 64'hFFFF);

    // Index 20: valid on 32 entries, dropped on 16 entries.
    @(negedge clock);
    reg_write0 = 1'b1; wr0 = 5'd20; wd0 = 64'h1234; rr2 = 5'd20;
    #1;
    check("x20_bypass", rd2, 64'h1234);
    check("x20_small_oor_bypass", sm_rd2, 64'h0);
    @(negedge clock);
    no_writes();
    #1;
    check("x20_stored", rd2, 64'h1234);
    check("x20_small_dropped", sm_rd2, 64'h0);

    // Without bypass a same-cycle read of x2 returns the previous value.
    @(negedge clock);
    reg_write0 = 1'b1; wr0 = 5'd2; wd0 = 64'h5;
    @(negedge clock);
    reg_write0 = 1'b1; wr0 = 5'd2; wd0 = 64'h9; rr1 = 5'd2;
    #1;
    check("x2_small_old_value", sm_rd1, 64'h5);
    check("x2_bypass_new_value", rd1, 64'h9);
    @(negedge clock);
    no_writes();
    #1;
    check("x2_small_new_value", sm_rd1, 64'h9);

    // Bulk clear of a fully loaded file.
    preload();
    rr1 = 5'd0; rr2 = 5'd30; rr3 = 5'd31;
    #1;
    check("preload_x0", rd1, 64'd1);
    check("preload_x30", rd2, 64'd31);
    check("preload_x31_zero_reg", rd3, 64'h0);
    check("preload_x31_nz", za_rd3, 64'd32);
    clear_start = 1'b1;
    watch(80, 1'b1, busy_n, done_n, busy_at_done);
    check("clear_busy_cycles", 64'(busy_n), 64'd32);
    check("clear_done_pulses", 64'(done_n), 64'd1);
    check("clear_done_follows_busy", 64'(busy_at_done), 64'd32);
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i);
      #1;
      check("after_clear_zero", rd1, 64'h0);
    end

    // Reset in the eleventh CLEAR cycle, then a fresh clear.
    preload();
    clear_start = 1'b1;
    @(negedge clock);
    clear_start = 1'b0;
    repeat (10) @(negedge clock);
    check("busy_at_cycle10", {63'h0, clear_busy}, 64'h1);
    rr1 = 5'd15; rr2 = 5'd30; rr3 = 5'd12;
    #1 reset_n = 1'b0;
    #1;
    check("midclear_reset_busy", {63'h0, clear_busy}, 64'h0);
    check("midclear_reset_done", {63'h0, clear_done}, 64'h0);
    check("midclear_reset_rd1", rd1, 64'h0);
    check("midclear_reset_rd2", rd2, 64'h0);
    check("midclear_reset_rd3", rd3, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("after_reset_x15", rd1, 64'h0);
    check("after_reset_x30", rd2, 64'h0);
    watch(5, 1'b0, busy_n, done_n, busy_at_done);
    check("after_reset_no_busy", 64'(busy_n), 64'd0);
    check("after_reset_no_done", 64'(done_n), 64'd0);
    clear_start = 1'b1;
    watch(60, 1'b0, busy_n, done_n, busy_at_done);
    check("reclear_busy_cycles", 64'(busy_n), 64'd32);
    check("reclear_done_pulses", 64'(done_n), 64'd1);
    check("reclear_done_follows_busy", 64'(busy_at_done), 64'd32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Multi-port integer register file for the ARM datapath; next generation of the single-write, two-read register array.
- Adds a third read port, two write ports with defined priority, a hard-wired zero register (XZR) and same-cycle write-to-read bypass.
- Adds an asynchronous reset and a sequenced bulk-clear engine with a busy/done handshake.
- Sits between decode (read addresses) and writeback (two retire lanes).

Parameters:
- DATA_WIDTH, 64, width of each register.
- ADDR_WIDTH, 5, register index width.
- NUM_REGS, 32, implemented registers (2 .. 2**ADDR_WIDTH).
- ZERO_REG_EN, 1, 1 = register ZERO_REG_INDEX reads 0 and ignores writes.
- ZERO_REG_INDEX, 31, index of XZR.
- BYPASS_EN, 1, 1 = same-cycle write data forwarded to reads.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- read_register1 / read_register2 / read_register3  in  ADDR_WIDTH  read indices.
- read_data1 / read_data2 / read_data3  out  DATA_WIDTH  read data, combinational.
- reg_write0, reg_write1  in  1  write enables, lane 0 and lane 1 (lane 1 is younger).
- write_register0, write_register1  in  ADDR_WIDTH  write indices.
- write_data0, write_data1  in  DATA_WIDTH  write data.
- clear_start  in  1  request bulk clear (single-cycle pulse or level, sampled in IDLE).
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse when clear completes.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All NUM_REGS registers = 0.
  - FSM = IDLE, clear counter = 0.
  - clear_busy = 0, clear_done = 0.
  - read_data* = 0 during reset.
- Valid write: reg_writeN=1, index < NUM_REGS, not (ZERO_REG_EN and index == ZERO_REG_INDEX), clear_busy=0. Committed at the rising edge. Invalid writes are dropped silently.
- Both lanes valid to the same index: lane 1 data is stored.
- Reads are combinational, with priority:
  1. Index >= NUM_REGS, or the zero register -> 0.
  2. BYPASS_EN=1 and clear_busy=0 and a valid write targets the index this cycle -> that write data (lane 1 over lane 0).
  3. Otherwise -> stored value.
- BYPASS_EN=0: reads return the stored value; a new write is visible the cycle after the edge.
- Clear FSM:
  - IDLE: clear_start=1 -> CLEAR at the next edge, counter = 0.
  - CLEAR: clear_busy=1; each edge writes 0 to register[counter] and increments the counter. When the counter reaches NUM_REGS-1, the edge clears it and moves to DONE. CLEAR lasts exactly NUM_REGS cycles.
  - DONE: clear_busy=0, clear_done=1 for one cycle -> IDLE.
  - clear_start in CLEAR or DONE is ignored (not queued).
  - Port writes during CLEAR are dropped, including writes to already-cleared entries.
  - Reads during CLEAR return current contents (partially cleared), zero-register/range rules still apply, no bypass.
- Reset asserted mid-CLEAR: immediate IDLE, all registers 0, no clear_done pulse.
- Counter width: ADDR_WIDTH bits, no wrap past NUM_REGS-1.

Test Plan:
- Reset then read all indices on three ports -> 0; write x5=0xDEAD_BEEF via lane 0 -> next cycle read_data1(5)=0xDEADBEEF, read_data2(4)=0.
- Same cycle, lane 0 writes x7=0x11 and lane 1 writes x7=0x22, read_register3=7 -> read_data3=0x22 in that cycle (bypass) and afterwards.
- Write x31=0xFFFF with ZERO_REG_EN=1 -> read x31 = 0; rerun with ZERO_REG_EN=0 -> reads 0xFFFF.
- Preload x0..x31 = index+1, pulse clear_start:
  - clear_busy high for exactly 32 cycles, then clear_done for 1 cycle.
  - Lane 0 write x3=0x55 mid-clear is dropped.
  - Afterwards all registers = 0.
- Start clear, deassert reset_n at cycle 10 of CLEAR -> clear_busy=0 immediately, no clear_done, all reads 0; a new clear_start after reset release runs normally.
- NUM_REGS=16 build: write index 20 -> dropped, read index 20 = 0; BYPASS_EN=0 build: write x2=0x9 and read x2 same cycle -> old value, new value the next cycle.
